control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 118 +++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Registered main decoder: maps a 7-bit opcode to datapath control signals one cycle later.
// Optional JAL/JALR decode is enabled by defining CU_JUMP_EN; otherwise those opcodes are illegal.
module control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   input  logic [6:0] opcode,
   output logic       alu_src,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       branch,
   output logic [1:0] aluop,
   output logic       jump,
   output logic       illegal
);

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_I      = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_CMP  = 2'b01,
      ALU_RFN  = 2'b10,
      ALU_IFN  = 2'b11
   } aluop_e;

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] aluop;
      logic       jump;
      logic       illegal;
   } ctrl_t;

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   // Unknown opcode bits match no case item and fall into default, so X decodes as illegal.
   always_comb begin
      ctrl_d = '0;
      if (instr_valid) begin
         case (opcode)
            OP_R: begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.aluop     = ALU_RFN;
            end
            OP_I: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.reg_write = 1'b1;
               ctrl_d.aluop     = ALU_IFN;
            end
            OP_LOAD: begin
               ctrl_d.alu_src    = 1'b1;
               ctrl_d.mem_to_reg = 1'b1;
               ctrl_d.reg_write  = 1'b1;
               ctrl_d.mem_read   = 1'b1;
               ctrl_d.aluop      = ALU_ADD;
            end
            OP_STORE: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.mem_write = 1'b1;
               ctrl_d.aluop     = ALU_ADD;
            end
            OP_BRANCH: begin
               ctrl_d.branch = 1'b1;
               ctrl_d.aluop  = ALU_CMP;
            end
`ifdef CU_JUMP_EN
            OP_JAL: begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.jump      = 1'b1;
            end
            OP_JALR: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.reg_write = 1'b1;
               ctrl_d.jump      = 1'b1;
            end
`endif
            default: ctrl_d.illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ctrl_q <= '0;
      else        ctrl_q <= ctrl_d;
   end

   assign alu_src    = ctrl_q.alu_src;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign reg_write  = ctrl_q.reg_write;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign branch     = ctrl_q.branch;
   assign aluop      = ctrl_q.aluop;
   assign illegal    = ctrl_q.illegal;
`ifdef CU_JUMP_EN
   assign jump       = ctrl_q.jump;
`else
   assign jump       = 1'b0;
   logic unused_jump;
   assign unused_jump = ctrl_q.jump;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver pushes expected tuples, monitor pops and compares.
// Expected tuples come from a lookup table of opcode -> output tuple; define CU_JUMP_EN to match the DUT build.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       instr_valid = 1'b0;
   logic [6:0] opcode = '0;
   logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, illegal;
   logic [1:0] aluop;

   int checks = 0;
   int errors = 0;

   // tuple order: alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, aluop[1:0], jump, illegal
   typedef struct {
      logic [6:0] op;
      logic [9:0] tup;
   } entry_t;

   entry_t     table_q[$];
   logic [9:0] exp_q[$];

   control_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .opcode      (opcode),
      .alu_src     (alu_src),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .branch      (branch),
      .aluop       (aluop),
      .jump        (jump),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] model(input logic v, input logic [6:0] op);
      if (v !== 1'b1) return 10'b0;
      foreach (table_q[i])
         if (table_q[i].op === op) return table_q[i].tup;
      return 10'b0000000001;
   endfunction

   function automatic logic [9:0] dut_tuple();
      return {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, aluop, jump, illegal};
   endfunction

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
      end
   endtask

   // Sets inputs for the coming rising edge and records the response it must produce.
   task automatic drive(input logic v, input logic [6:0] op);
      instr_valid = v;
      opcode      = op;
      exp_q.push_back(model(instr_valid, opcode));
   endtask

   task automatic issue(input logic v, input logic [6:0] op);
      @(negedge clk);
      drive(v, op);
   endtask

   // Monitor: every rising edge out of reset presents one decode.
   initial begin
      logic [9:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("decode", dut_tuple(), e);
         end
         checks++;
         if ((mem_read && mem_write) || (branch && jump)) begin
            errors++;
            $display("FAIL exclusive got=%b want=no_overlap at %0t", dut_tuple(), $time);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] legal_ops[$];
      logic [6:0] op;
      int         cycles;

      table_q.push_back('{7'b0110011, 10'b0010001000});
      table_q.push_back('{7'b0010011, 10'b1010001100});
      table_q.push_back('{7'b0000011, 10'b1111000000});
      table_q.push_back('{7'b0100011, 10'b1000100000});
      table_q.push_back('{7'b1100011, 10'b0000010100});
`ifdef CU_JUMP_EN
      table_q.push_back('{7'b1101111, 10'b0010000010});
      table_q.push_back('{7'b1100111, 10'b1010000010});
`endif
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111};

      // Reset with an R-type pending: outputs must be zero without any clock edge.
      #1;
      rst_n = 1'b0;
      instr_valid = 1'b1;
      opcode = 7'b0110011;
      #1;
      check("reset_async", dut_tuple(), 10'b0);
      @(negedge clk);
      #1;
      check("reset_hold", dut_tuple(), 10'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 7'b0110011);

      // Valid-opcode sweep
      issue(1'b1, 7'b0110011);
      issue(1'b1, 7'b0010011);
      issue(1'b1, 7'b0000011);
      issue(1'b1, 7'b0100011);
      issue(1'b1, 7'b1100011);

      // Illegal opcode then bubble, load bubble, low-bit illegal
      issue(1'b1, 7'b1111111);
      issue(1'b0, 7'b1111111);
      issue(1'b0, 7'b0000011);
      issue(1'b1, 7'b0000010);

      // Jump opcodes
      issue(1'b1, 7'b1101111);
      issue(1'b1, 7'b1100111);

      // Unknown opcode bits
      issue(1'b1, 7'bx0x0011);
      issue(1'b1, 7'b0110011);

      // Mid-stream reset while a store is decoded and a load is pending
      issue(1'b1, 7'b0100011);
      issue(1'b1, 7'b0000011);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midreset_async", dut_tuple(), 10'b0);
      @(posedge clk);
      #1;
      check("midreset_discard", dut_tuple(), 10'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 7'b0100011);

      // Randomized stream
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0) op = legal_ops[$urandom_range(0, 6)];
         else                           op = 7'($urandom);
         issue($urandom_range(0, 4) != 0, op);
      end

      cycles = 0;
      while (exp_q.size() > 0 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain got=%0d want=0 pending", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
